// File: rtl/reflet_float_mult_seq_pkg.sv
// Shared definitions for the sequential Reflet floating-point multiplier:
// FSM encoding, flag patterns and format helpers.
package reflet_float_mult_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Flag vectors are {invalid, overflow, underflow, inexact}
    localparam logic [3:0] FLAG_NONE    = 4'b0000;
    localparam logic [3:0] FLAG_INVALID = 4'b1000;
    localparam logic [3:0] FLAG_OVF     = 4'b0101;
    localparam logic [3:0] FLAG_UNF     = 4'b0011;

    function automatic int mantissa_size(input int size);
        case (size)
            32'sd16: mantissa_size = 32'sd10;
            32'sd64: mantissa_size = 32'sd52;
            default: mantissa_size = 32'sd23;
        endcase
    endfunction

    function automatic int exponent_size(input int size);
        case (size)
            32'sd16: exponent_size = 32'sd5;
            32'sd64: exponent_size = 32'sd11;
            default: exponent_size = 32'sd8;
        endcase
    endfunction

    function automatic int exponent_bias(input int size);
        exponent_bias = (32'sd1 <<< (exponent_size(size) - 32'sd1)) - 32'sd1;
    endfunction

    function automatic logic [63:0] float_nan(input int size);
        float_nan = (((64'd1 << exponent_size(size)) - 64'd1) << mantissa_size(size))
                  | (64'd1 << (mantissa_size(size) - 32'sd1));
    endfunction

    function automatic logic [63:0] float_inf(input int size, input logic sign);
        float_inf = (((64'd1 << exponent_size(size)) - 64'd1) << mantissa_size(size))
                  | ({63'd0, sign} << (size - 32'sd1));
    endfunction

endpackage

// File: rtl/reflet_float_mult_iter.sv
// Shift-add significand multiplier consuming bits_per_cycle multiplier bits
// per clock; done flags the cycle that performs the final iteration.
module reflet_float_mult_iter #(
    parameter int mnt_size       = 23,
    parameter int bits_per_cycle = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [mnt_size:0]     sig_a,
    input  logic [mnt_size:0]     sig_b,
    output logic [2*mnt_size+1:0] product,
    output logic                  done
);
    localparam int SW = mnt_size + 1;
    localparam int N  = (SW + bits_per_cycle - 1) / bits_per_cycle;
    localparam int MW = N * bits_per_cycle;
    localparam int PW = 2 * SW;
    localparam int CW = $clog2(N + 1);

    logic [PW-1:0] acc_q, acc_d, mcand_q, mcand_d, partial_s;
    logic [MW-1:0] mplier_q, mplier_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Partial product of the low multiplier digit; bits past the product width are never set.
    always_comb begin
        partial_s = {PW{1'b0}};
        for (int j = 0; j < bits_per_cycle; j++) begin
            if (mplier_q[j]) begin
                partial_s = partial_s + (mcand_q << j);
            end else begin
                partial_s = partial_s;
            end
        end
    end

    // Load on start, otherwise iterate until the counter drains.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start) begin
            acc_d    = {PW{1'b0}};
            mcand_d  = {{SW{1'b0}}, sig_a};
            mplier_d = MW'(sig_b);
            cnt_d    = CW'(N);
        end else if (cnt_q != {CW{1'b0}}) begin
            acc_d    = acc_q + partial_s;
            mcand_d  = mcand_q << bits_per_cycle;
            mplier_d = mplier_q >> bits_per_cycle;
            cnt_d    = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            acc_d = acc_q;
        end
    end

    // Core state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q    <= {PW{1'b0}};
            mcand_q  <= {PW{1'b0}};
            mplier_q <= {MW{1'b0}};
            cnt_q    <= {CW{1'b0}};
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign product = acc_q;
    assign done    = (cnt_q == {{(CW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/reflet_float_mult_seq.sv
// Sequential IEEE-754-style multiplier with round-to-nearest-even,
// overflow/underflow saturation and exception flags; level enable/ready handshake.
module reflet_float_mult_seq
    import reflet_float_mult_seq_pkg::*;
#(
    parameter int float_size     = 32,
    parameter int bits_per_cycle = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [float_size-1:0] in1,
    input  logic [float_size-1:0] in2,
    output logic [float_size-1:0] mult,
    output logic                  ready,
    output logic [3:0]            flags
);
    localparam int M  = mantissa_size(float_size);
    localparam int E  = exponent_size(float_size);
    localparam int EW = E + 2;
    localparam int PW = 2 * M + 2;
    localparam logic [63:0]           NAN_64    = float_nan(float_size);
    localparam logic [63:0]           INF_64    = float_inf(float_size, 1'b0);
    localparam logic [float_size-1:0] NAN_C     = NAN_64[float_size-1:0];
    localparam logic [float_size-1:0] INF_C     = INF_64[float_size-1:0];
    localparam logic [EW-1:0]         BIAS_C    = EW'(exponent_bias(float_size));
    localparam logic [EW-1:0]         EXP_MAX_C = EW'((32'sd1 <<< E) - 32'sd1);

    state_e                state_q, state_d;
    logic [float_size-1:0] in1_q, in1_d, in2_q, in2_d, mult_q, mult_d;
    logic [3:0]            flags_q, flags_d;
    logic                  sign_q, sign_d;
    logic [E-1:0]          exp1_q, exp1_d, exp2_q, exp2_d;

    logic [E-1:0]          exp_a_s, exp_b_s;
    logic [M-1:0]          mnt_a_s, mnt_b_s;
    logic                  sign_s, nan_a_s, nan_b_s, inf_a_s, inf_b_s, zero_a_s, zero_b_s;
    logic                  changed_s, start_s, iter_done_s;
    logic [PW-1:0]         product_s;
    logic [PW-2:0]         norm_s;
    logic [M-1:0]          mant_s;
    logic [M:0]            mant_r_s;
    logic                  guard_s, sticky_s, round_up_s;
    logic [EW-1:0]         exp_sum_s;
    logic [float_size-1:0] round_result_s, signed_zero_s;
    logic [3:0]            round_flags_s;

    assign exp_a_s   = in1[M+E-1:M];
    assign exp_b_s   = in2[M+E-1:M];
    assign mnt_a_s   = in1[M-1:0];
    assign mnt_b_s   = in2[M-1:0];
    assign sign_s    = in1[float_size-1] ^ in2[float_size-1];
    assign nan_a_s   = (&exp_a_s) & (|mnt_a_s);
    assign nan_b_s   = (&exp_b_s) & (|mnt_b_s);
    assign inf_a_s   = (&exp_a_s) & ~(|mnt_a_s);
    assign inf_b_s   = (&exp_b_s) & ~(|mnt_b_s);
    assign zero_a_s  = ~(|exp_a_s);
    assign zero_b_s  = ~(|exp_b_s);
    assign changed_s = (in1 != in1_q) || (in2 != in2_q);
    assign signed_zero_s = {sign_q, {(float_size-1){1'b0}}};

    reflet_float_mult_iter #(
        .mnt_size       (M),
        .bits_per_cycle (bits_per_cycle)
    ) u_iter (
        .clk     (clk),
        .reset   (reset),
        .start   (start_s),
        .sig_a   ({1'b1, mnt_a_s}),
        .sig_b   ({1'b1, mnt_b_s}),
        .product (product_s),
        .done    (iter_done_s)
    );

    // Normalise, round to nearest even and saturate the exponent range.
    always_comb begin
        norm_s     = product_s[PW-1] ? product_s[PW-2:0] : {product_s[PW-3:0], 1'b0};
        mant_s     = norm_s[2*M:M+1];
        guard_s    = norm_s[M];
        sticky_s   = |norm_s[M-1:0];
        round_up_s = guard_s & (sticky_s | mant_s[0]);
        mant_r_s   = {1'b0, mant_s} + {{M{1'b0}}, round_up_s};
        // Unsigned EW-bit sum is the two's-complement signed exponent.
        exp_sum_s  = {2'b00, exp1_q} + {2'b00, exp2_q} - BIAS_C
                   + {{(EW-1){1'b0}}, product_s[PW-1]} + {{(EW-1){1'b0}}, mant_r_s[M]};
        round_result_s = {sign_q, exp_sum_s[E-1:0], mant_r_s[M-1:0]};
        round_flags_s  = {3'b000, guard_s | sticky_s};
        if (!exp_sum_s[EW-1] && (exp_sum_s >= EXP_MAX_C)) begin
            round_result_s = signed_zero_s | INF_C;
            round_flags_s  = FLAG_OVF;
        end else if (exp_sum_s[EW-1] || (exp_sum_s == {EW{1'b0}})) begin
            round_result_s = signed_zero_s;
            round_flags_s  = FLAG_UNF;
        end else begin
            round_flags_s  = {3'b000, guard_s | sticky_s};
        end
    end

    // Next-state logic: capture/classify, iterate, round, hold.
    always_comb begin
        state_d = state_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        sign_d  = sign_q;
        exp1_d  = exp1_q;
        exp2_d  = exp2_q;
        mult_d  = mult_q;
        flags_d = flags_q;
        start_s = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            mult_d  = {float_size{1'b0}};
            flags_d = FLAG_NONE;
        end else if ((state_q == ST_IDLE) || changed_s) begin
            in1_d   = in1;
            in2_d   = in2;
            sign_d  = sign_s;
            exp1_d  = exp_a_s;
            exp2_d  = exp_b_s;
            mult_d  = {float_size{1'b0}};
            flags_d = FLAG_NONE;
            state_d = ST_DONE;
            if (nan_a_s || nan_b_s || (inf_a_s && zero_b_s) || (zero_a_s && inf_b_s)) begin
                mult_d  = NAN_C;
                flags_d = FLAG_INVALID;
            end else if (inf_a_s || inf_b_s) begin
                mult_d  = {sign_s, {(float_size-1){1'b0}}} | INF_C;
            end else if (zero_a_s || zero_b_s) begin
                mult_d  = {sign_s, {(float_size-1){1'b0}}};
            end else begin
                start_s = 1'b1;
                state_d = ST_ITER;
            end
        end else begin
            case (state_q)
                ST_ITER: begin
                    if (iter_done_s) begin
                        state_d = ST_ROUND;
                    end else begin
                        state_d = ST_ITER;
                    end
                end
                ST_ROUND: begin
                    mult_d  = round_result_s;
                    flags_d = round_flags_s;
                    state_d = ST_DONE;
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            in1_q   <= {float_size{1'b0}};
            in2_q   <= {float_size{1'b0}};
            sign_q  <= 1'b0;
            exp1_q  <= {E{1'b0}};
            exp2_q  <= {E{1'b0}};
            mult_q  <= {float_size{1'b0}};
            flags_q <= FLAG_NONE;
        end else begin
            state_q <= state_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            sign_q  <= sign_d;
            exp1_q  <= exp1_d;
            exp2_q  <= exp2_d;
            mult_q  <= mult_d;
            flags_q <= flags_d;
        end
    end

    assign ready = enable & (state_q == ST_DONE) & ~changed_s;
    assign mult  = ready ? mult_q : {float_size{1'b0}};
    assign flags = ready ? flags_q : FLAG_NONE;

endmodule

// File: tb/tb_reflet_float_mult_seq.sv
// Self-checking bench: directed vector table, hand sequences for abort/reset,
// and random operands against an arithmetic reference model.
module tb_reflet_float_mult_seq;

    logic        clk;
    logic        reset;
    logic        en32, en16;
    logic [31:0] a32, b32, m_b1, m_b4;
    logic [15:0] a16, b16, m16;
    logic        rdy_b1, rdy_b4, rdy16;
    logic [3:0]  fl_b1, fl_b4, fl16;
    int          n_tests = 0;
    int          n_fail  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] m;
        logic [3:0]  f;
        int          l1;
        int          l4;
    } vec_t;
    vec_t vecs[10];

    reflet_float_mult_seq #(.float_size(32), .bits_per_cycle(1)) dut_b1 (
        .clk(clk), .reset(reset), .enable(en32), .in1(a32), .in2(b32),
        .mult(m_b1), .ready(rdy_b1), .flags(fl_b1));
    reflet_float_mult_seq #(.float_size(32), .bits_per_cycle(4)) dut_b4 (
        .clk(clk), .reset(reset), .enable(en32), .in1(a32), .in2(b32),
        .mult(m_b4), .ready(rdy_b4), .flags(fl_b4));
    reflet_float_mult_seq #(.float_size(16), .bits_per_cycle(1)) dut_16 (
        .clk(clk), .reset(reset), .enable(en16), .in1(a16), .in2(b16),
        .mult(m16), .ready(rdy16), .flags(fl16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Exact integer product, then rounding by remainder against one half ulp.
    function automatic void ref_mul(input int mw, input int ew, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] res,
                                    output logic [3:0] fl, output bit special);
        longint unsigned emax, mmask, ea, eb, fa, fb, p, q, r, half, sbit, infb;
        int e, sh;
        bit nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        emax  = (64'd1 << ew) - 64'd1;
        mmask = (64'd1 << mw) - 64'd1;
        ea = (a >> mw) & emax;  eb = (b >> mw) & emax;
        fa = a & mmask;         fb = b & mmask;
        sbit = (((a >> (mw + ew)) ^ (b >> (mw + ew))) & 64'd1) << (mw + ew);
        infb = emax << mw;
        nan_a = (ea == emax) && (fa != 0);  nan_b = (eb == emax) && (fb != 0);
        inf_a = (ea == emax) && (fa == 0);  inf_b = (eb == emax) && (fb == 0);
        zero_a = (ea == 0);                 zero_b = (eb == 0);
        fl = 4'b0000;
        special = 1'b1;
        res = 64'd0;
        if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
            res = infb | (64'd1 << (mw - 1));
            fl  = 4'b1000;
        end else if (inf_a || inf_b) begin
            res = sbit | infb;
        end else if (zero_a || zero_b) begin
            res = sbit;
        end else begin
            special = 1'b0;
            p  = ((64'd1 << mw) | fa) * ((64'd1 << mw) | fb);
            e  = int'(ea) + int'(eb) - ((1 << (ew - 1)) - 1);
            sh = (p >= (64'd1 << (2 * mw + 1))) ? mw + 1 : mw;
            if (sh == mw + 1) e++;
            q    = p >> sh;
            r    = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if ((r > half) || ((r == half) && q[0])) q++;
            if (q == (64'd1 << (mw + 1))) begin
                q = q >> 1;
                e++;
            end
            if (e >= int'(emax)) begin
                res = sbit | infb;
                fl  = 4'b0101;
            end else if (e <= 0) begin
                res = sbit;
                fl  = 4'b0011;
            end else begin
                res = sbit | (longint'(e) << mw) | (q & mmask);
                fl  = {3'b000, r != 0};
            end
        end
    endfunction

    task automatic wait_lat32(output int l1, output int l4);
        l1 = 0;
        l4 = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (rdy_b4 && l4 == 0) l4 = c;
            if (rdy_b1 && l1 == 0) l1 = c;
            if (l1 != 0 && l4 != 0) break;
        end
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] em,
                         input logic [3:0] ef, input int el1, input int el4, input string tag);
        int l1, l4;
        en32 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a32 = a; b32 = b; en32 = 1'b1;
        wait_lat32(l1, l4);
        chk({tag, " lat_b1"}, l1, el1);
        chk({tag, " lat_b4"}, l4, el4);
        chk({tag, " mult_b1"}, m_b1, em);
        chk({tag, " flags_b1"}, fl_b1, ef);
        chk({tag, " mult_b4"}, m_b4, em);
        chk({tag, " flags_b4"}, fl_b4, ef);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] em,
                         input logic [3:0] ef, input int el, input string tag);
        int l;
        en16 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a16 = a; b16 = b; en16 = 1'b1;
        l = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (rdy16) begin
                l = c;
                break;
            end
        end
        chk({tag, " lat16"}, l, el);
        chk({tag, " mult16"}, m16, em);
        chk({tag, " flags16"}, fl16, ef);
    endtask

    function automatic logic [31:0] rnd32();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r = r;
            1: r[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            2: begin
                r[22:0]  = 23'd0;
                r[30:23] = 8'($urandom_range(1, 254));
            end
            3: r[30:23] = 8'($urandom_range(1, 254));
            default: r[30:23] = 8'($urandom_range(64, 190));
        endcase
        return r;
    endfunction

    function automatic logic [15:0] rnd16();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 7))
            0: r = r;
            1: r[14:10] = ($urandom_range(0, 1) == 1) ? 5'h1F : 5'h00;
            2: r[14:10] = 5'($urandom_range(1, 30));
            default: r[14:10] = 5'($urandom_range(8, 22));
        endcase
        return r;
    endfunction

    initial begin
        logic [63:0] r;
        logic [3:0]  f;
        bit          sp;
        logic [31:0] a, b;
        logic [15:0] a_h, b_h;
        int          l1, l4;

        vecs[0] = '{32'h3FC00000, 32'hC0000000, 32'hC0400000, 4'b0000, 26, 8};
        vecs[1] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1, 1};
        vecs[2] = '{32'h7F800000, 32'hBF800000, 32'hFF800000, 4'b0000, 1, 1};
        vecs[3] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, 26, 8};
        vecs[4] = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 26, 8};
        vecs[5] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 26, 8};
        vecs[6] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 26, 8};
        vecs[7] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1, 1};
        vecs[8] = '{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 1, 1};
        vecs[9] = '{32'h00000001, 32'hFF800000, 32'h7FC00000, 4'b1000, 1, 1};

        // Reset state, with enable already requesting work.
        reset = 1'b0;
        en32 = 1'b1; a32 = 32'h3FC00000; b32 = 32'hC0000000;
        en16 = 1'b1; a16 = 16'h3E00;     b16 = 16'h4000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready_b1", rdy_b1, 1'b0);
        chk("reset mult_b1", m_b1, 32'h0);
        chk("reset flags_b1", fl_b1, 4'h0);
        chk("reset ready_b4", rdy_b4, 1'b0);
        chk("reset ready16", rdy16, 1'b0);
        @(negedge clk);
        en32 = 1'b0; en16 = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run32(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].f, vecs[i].l1, vecs[i].l4,
                  $sformatf("vec%0d", i));
        end

        // Result held in DONE while enable stays high.
        repeat (3) @(posedge clk);
        #1;
        chk("hold ready_b1", rdy_b1, 1'b1);
        chk("hold mult_b1", m_b1, vecs[9].m);

        // Drop enable mid-iteration, then re-request: full latency again.
        en32 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a32 = 32'h3FC00000; b32 = 32'hC0000000; en32 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort pre ready_b4", rdy_b4, 1'b1);
        chk("abort pre ready_b1", rdy_b1, 1'b0);
        @(negedge clk);
        en32 = 1'b0;
        #1;
        chk("abort ready_b4", rdy_b4, 1'b0);
        chk("abort mult_b4", m_b4, 32'h0);
        @(posedge clk);
        #1;
        chk("abort ready_b1", rdy_b1, 1'b0);
        chk("abort mult_b1", m_b1, 32'h0);
        @(negedge clk);
        en32 = 1'b1;
        wait_lat32(l1, l4);
        chk("reenable lat_b1", l1, 26);
        chk("reenable lat_b4", l4, 8);
        chk("reenable mult_b1", m_b1, 32'hC0400000);

        // Asynchronous reset mid-operation clears outputs at once.
        en32 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a32 = 32'h3F800001; b32 = 32'h3F800001; en32 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rstmid pre ready_b4", rdy_b4, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstmid ready_b4", rdy_b4, 1'b0);
        chk("rstmid mult_b4", m_b4, 32'h0);
        chk("rstmid flags_b4", fl_b4, 4'h0);
        chk("rstmid ready_b1", rdy_b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_lat32(l1, l4);
        chk("rstrel lat_b1", l1, 26);
        chk("rstrel lat_b4", l4, 8);
        chk("rstrel mult_b1", m_b1, 32'h3F800002);
        chk("rstrel flags_b1", fl_b1, 4'b0001);

        // Input change while busy restarts with the new operands.
        en32 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a32 = 32'h3FC00000; b32 = 32'hC0000000; en32 = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        a32 = 32'h40400000; b32 = 32'h40000000;
        wait_lat32(l1, l4);
        chk("change lat_b1", l1, 26);
        chk("change mult_b1", m_b1, 32'h40C00000);
        chk("change mult_b4", m_b4, 32'h40C00000);

        // Half precision directed case.
        run16(16'h3E00, 16'h4000, 16'h4200, 4'b0000, 13, "h_1p5x2");

        for (int i = 0; i < 1500; i++) begin
            a = rnd32();
            b = rnd32();
            ref_mul(23, 8, {32'd0, a}, {32'd0, b}, r, f, sp);
            run32(a, b, r[31:0], f, sp ? 1 : 26, sp ? 1 : 8, "rnd32");
        end

        for (int i = 0; i < 600; i++) begin
            a_h = rnd16();
            b_h = rnd16();
            ref_mul(10, 5, {48'd0, a_h}, {48'd0, b_h}, r, f, sp);
            run16(a_h, b_h, r[15:0], f, sp ? 1 : 13, "rnd16");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reflet_float_mult_seq.md
# reflet_float_mult_seq

Sequential, parametrised IEEE-754-style floating-point multiplier for the Reflet FPU, the next generation of the single-shot multiplier. It computes the significand product iteratively in a `bits_per_cycle`-wide shift-add core and handles special operands. It adds round-to-nearest-even, overflow/underflow saturation and exception flags. It sits beside the other `floating_points_opperations` blocks and uses the same level-`enable` / `ready` handshake, so the FPU sequencer drives it unchanged.

## Interface
- `float_size`, 32: total width (16, 32, 64); field widths from `mantissa_size()`, `exponent_size()`, `exponent_bias()`.
- `bits_per_cycle`, 1: multiplier bits consumed per iteration (1, 2, 4; must divide M+1 rounded up).
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level request; high = compute `in1*in2`.
- `in1`, `in2`  in  float_size  operands, held stable while `enable` high.
- `mult`  out  float_size  result; 0 whenever `ready` low.
- `ready`  out  1  result valid.
- `flags`  out  4  {invalid, overflow, underflow, inexact}, valid with `ready`, else 0.

## Operation
- M = mantissa_size, E = exponent_size, N = ceil((M+1)/bits_per_cycle) iterations.
- States: IDLE, ITER, ROUND, DONE.
- IDLE, `enable`=1: capture operands, signs, exponents, significands {1,mnt}; classify. A special case loads `mult`/`flags` directly and goes to DONE. Otherwise, clear the accumulator, load the iteration counter with N, and go to ITER.
- ITER: add `multiplicand*multiplier[bits_per_cycle-1:0]` to the accumulator, shift the multiplier right, and decrement the counter. Go to ROUND when the counter reaches 1.
- ROUND: 2M+2-bit product.
  - If bit 2M+1 is set, shift right 1 and add 1 to the exponent.
  - Take M result bits plus guard bit and sticky (OR of the rest), and round to nearest even.
  - A rounding carry-out renormalises (exponent +1).
  - The exponent is computed in E+2-bit signed arithmetic: e1+e2-bias+adj.
  - Biased exponent ≥ 2^E-1 gives signed infinity with overflow and inexact set.
  - Biased exponent ≤ 0 gives signed zero with underflow and inexact set; subnormals are not produced.
  - Then go to DONE.
- DONE: hold `mult`, `flags`, `ready`=1 while `enable`=1 and the inputs are unchanged.
- `enable` low in any state: go to IDLE next edge; `ready`, `mult` and `flags` are 0 (combinationally gated by `enable`).
- An input change while `enable` is high (compared against the captured copy) aborts the operation and restarts from IDLE capture on the next edge.
- Special cases:
  - Either input NaN, or inf×0: canonical NaN {0, all-ones exponent, 1, zeros}, invalid=1.
  - inf×finite-nonzero: signed inf, no flags.
  - Zero or subnormal operand (exponent 0): treated as zero, result signed zero, no flags.
  - Sign of the result is always sign1 XOR sign2, except NaN.

## Timing
- Reset: state IDLE; `ready`=0, `mult`=0, `flags`=0; all registers cleared.
- Normal latency: capture at edge 0, ITER at edges 1..N, ROUND at edge N+1. `ready` is high after edge N+1 (N+2 cycles with `enable` high), e.g. 26 cycles for 32-bit, B=1, and 8 cycles for B=4.
- Special-case latency: `ready` is high after edge 0.
- Reset asserted mid-ITER: immediate return to the reset state. After release, computation restarts only from IDLE with `enable` high.
- Back-to-back operations need `enable` low for at least one cycle, or a change of inputs.

## Structure
- Shared header `reflet_float_functions.vh`: `mantissa_size`, `exponent_size`, `exponent_bias`. Add `float_nan(size)` and `float_inf(size, sign)` there.
- State encodings as `localparam`s in `reflet_float_opperations.vh`.
- Sub-module `reflet_float_mult_iter`: shift-add core with accumulator, counter and `bits_per_cycle` generalisation. Interface: `clk`, `reset`, `start`, two significands; outputs `product` and `done`.

## Test plan
- 32-bit, B=1: 0x3FC00000×0xC0000000 → `mult`=0xC0400000, flags 0, `ready` after exactly 26 cycles. Repeat with B=4 → 8 cycles.
- 0x7F800000×0x00000000 → 0x7FC00000, invalid=1, `ready` after 1 cycle. 0x7F800000×0xBF800000 → 0xFF800000.
- 0x7F000000×0x40000000 → 0x7F800000, overflow=1, inexact=1. 0x00800000×0x3F000000 → 0x00000000, underflow=1.
- 0x3F800001×0x3F800001 → 0x3F800002, inexact=1. 0x3F800000×0x3F800000 → 0x3F800000, inexact=0.
- Drop `enable` at iteration 10 → `ready`=0, `mult`=0 next cycle. Pull `reset` low mid-ITER → all outputs 0 immediately. Re-assert `enable` → full latency again.
- float_size=16: 0x3E00×0x4000 (1.5×2) → 0x4200 after N+2=13 cycles. Random 10k operands against a reference model with round-to-nearest-even.
